// File: rtl/if_id_queue_pkg.sv
// Shared processor constants: fetch/decode word width, IF/ID queue depth,
// and the NOP encoding that decode also relies on.
package if_id_queue_pkg;

  localparam int          IFQ_WIDTH = 16;
  localparam int          IFQ_DEPTH = 2;
  localparam logic [15:0] NOP_INSTR = 16'h0000;

endpackage

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: a 2-entry FIFO between fetch and decode.
// inReady comes only from registered count, so fetch stall timing never
// depends on decode's outReady. Outputs have no bypass (1-cycle latency)
// and read as NOP while empty. flush dominates push and pop.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int WIDTH = IFQ_WIDTH,
  // Pointers are 1 bit wide, so only a depth of 2 is meaningful.
  parameter int DEPTH = IFQ_DEPTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             inValid,
  input  logic [WIDTH-1:0] instrIn,
  input  logic [WIDTH-1:0] pc4In,
  output logic             inReady,
  input  logic             flush,
  output logic             outValid,
  output logic [WIDTH-1:0] instrOut,
  output logic [WIDTH-1:0] pc4Out,
  input  logic             outReady,
  output logic [1:0]       count
);

  logic [1:0][WIDTH-1:0] r_instr;
  logic [1:0][WIDTH-1:0] r_pc4;
  logic                  r_head;
  logic                  r_tail;
  logic [1:0]            r_count;

  logic                  w_valid;
  logic                  w_ready;
  logic                  w_push;
  logic                  w_pop;

  assign w_valid = (r_count != 2'd0);
  assign w_ready = (r_count < 2'(DEPTH));
  assign w_push  = inValid & w_ready & ~flush;
  assign w_pop   = w_valid & outReady & ~flush;

  // Storage is never cleared; validity lives entirely in r_count.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_instr[r_tail] <= instrIn;
      r_pc4[r_tail]   <= pc4In;
    end
  end

  // Pointer and occupancy update; flush empties the queue and rewinds pointers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      r_count <= 2'd0;
    end else if (flush) begin
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) r_tail <= ~r_tail;
      if (w_pop)  r_head <= ~r_head;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign inReady  = w_ready;
  assign outValid = w_valid;
  assign count    = r_count;
  assign instrOut = w_valid ? r_instr[r_head] : WIDTH'(NOP_INSTR);
  assign pc4Out   = w_valid ? r_pc4[r_head]   : WIDTH'(NOP_INSTR);

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed scenarios with explicit checks plus a
// negedge monitor that keeps its own FIFO model and scoreboard queue.
module tb_if_id_queue;

  logic        clock;
  logic        reset_n;
  logic        inValid;
  logic [15:0] instrIn;
  logic [15:0] pc4In;
  logic        inReady;
  logic        flush;
  logic        outValid;
  logic [15:0] instrOut;
  logic [15:0] pc4Out;
  logic        outReady;
  logic [1:0]  count;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_instr[$];
  logic [15:0] exp_pc4[$];
  int          m_count = 0;

  if_id_queue #(.WIDTH(16), .DEPTH(2)) dut (
    .clock(clock), .reset_n(reset_n), .inValid(inValid), .instrIn(instrIn),
    .pc4In(pc4In), .inReady(inReady), .flush(flush), .outValid(outValid),
    .instrOut(instrOut), .pc4Out(pc4Out), .outReady(outReady), .count(count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare DUT against the model, then advance the model with the
  // inputs that will be sampled at the coming rising edge.
  initial begin
    bit do_push, do_pop;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        chk("mon_rst_count", 32'(count), 32'd0);
        chk("mon_rst_valid", 32'(outValid), 32'd0);
        exp_instr.delete();
        exp_pc4.delete();
        m_count = 0;
        continue;
      end
      chk("mon_count", 32'(count), 32'(m_count));
      chk("mon_count_le2", 32'(count <= 2'd2), 32'd1);
      chk("mon_inReady", 32'(inReady), 32'(m_count < 2));
      chk("mon_outValid", 32'(outValid), 32'(m_count > 0));
      if (m_count == 0) begin
        chk("mon_nop_instr", 32'(instrOut), 32'h0);
        chk("mon_nop_pc4", 32'(pc4Out), 32'h0);
      end else if (exp_instr.size() > 0) begin
        chk("mon_head_instr", 32'(instrOut), 32'(exp_instr[0]));
        chk("mon_head_pc4", 32'(pc4Out), 32'(exp_pc4[0]));
      end
      if (flush) begin
        exp_instr.delete();
        exp_pc4.delete();
        m_count = 0;
      end else begin
        do_pop  = (m_count > 0) && outReady;
        do_push = inValid && (m_count < 2);
        if (do_pop && exp_instr.size() > 0) begin
          void'(exp_instr.pop_front());
          void'(exp_pc4.pop_front());
          m_count--;
        end
        if (do_push) begin
          exp_instr.push_back(instrIn);
          exp_pc4.push_back(pc4In);
          m_count++;
        end
      end
    end
  end

  // Drive one cycle of inputs, then return 1 time unit after the rising edge.
  task automatic cyc(input logic v, input logic [15:0] ins, input logic [15:0] pc,
                     input logic rdy, input logic fl);
    inValid  = v;
    instrIn  = ins;
    pc4In    = pc;
    outReady = rdy;
    flush    = fl;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; inValid = 1'b0; instrIn = '0; pc4In = '0;
    outReady = 1'b0; flush = 1'b0;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_outValid", 32'(outValid), 32'd0);
    chk("rst_inReady", 32'(inReady), 32'd1);
    chk("rst_instrOut", 32'(instrOut), 32'h0);
    chk("rst_pc4Out", 32'(pc4Out), 32'h0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset_n = 1'b1;

    // First push right after reset release, visible one cycle later
    cyc(1, 16'h1234, 16'h0002, 0, 0);
    chk("p1_outValid", 32'(outValid), 32'd1);
    chk("p1_instr", 32'(instrOut), 32'h1234);
    chk("p1_pc4", 32'(pc4Out), 32'h0002);
    chk("p1_count", 32'(count), 32'd1);
    cyc(0, 16'h0, 16'h0, 1, 0);
    chk("p1_drain", 32'(count), 32'd0);

    // Fill, rejected third push, drain in order
    cyc(1, 16'hAAAA, 16'h00A2, 0, 0);
    cyc(1, 16'hBBBB, 16'h00B2, 0, 0);
    chk("full_count", 32'(count), 32'd2);
    chk("full_inReady", 32'(inReady), 32'd0);
    cyc(1, 16'hCCCC, 16'h00C2, 0, 0);
    chk("full_ignore_count", 32'(count), 32'd2);
    chk("full_head", 32'(instrOut), 32'hAAAA);
    cyc(0, 16'h0, 16'h0, 1, 0);
    chk("pop1_instr", 32'(instrOut), 32'hBBBB);
    chk("pop1_pc4", 32'(pc4Out), 32'h00B2);
    cyc(0, 16'h0, 16'h0, 1, 0);
    chk("pop2_outValid", 32'(outValid), 32'd0);
    chk("pop2_instr", 32'(instrOut), 32'h0);

    // Full with push+pop: push refused, count drops to 1
    cyc(1, 16'hEEEE, 16'h00E2, 0, 0);
    cyc(1, 16'hFFFF, 16'h00F2, 0, 0);
    cyc(1, 16'h9999, 16'h0092, 1, 0);
    chk("fullpp_count", 32'(count), 32'd1);
    chk("fullpp_head", 32'(instrOut), 32'hFFFF);
    cyc(0, 16'h0, 16'h0, 1, 0);
    chk("fullpp_empty", 32'(outValid), 32'd0);

    // count=1 with simultaneous push and pop
    cyc(1, 16'h1111, 16'h0012, 0, 0);
    cyc(1, 16'h2222, 16'h0022, 1, 0);
    chk("pp_count", 32'(count), 32'd1);
    chk("pp_instr", 32'(instrOut), 32'h2222);
    chk("pp_pc4", 32'(pc4Out), 32'h0022);
    cyc(0, 16'h0, 16'h0, 1, 0);

    // Flush while full with a same-cycle push
    cyc(1, 16'h5555, 16'h0052, 0, 0);
    cyc(1, 16'h6666, 16'h0062, 0, 0);
    cyc(1, 16'h3333, 16'h0032, 0, 1);
    chk("fl_count", 32'(count), 32'd0);
    chk("fl_outValid", 32'(outValid), 32'd0);
    chk("fl_inReady", 32'(inReady), 32'd1);
    chk("fl_instr", 32'(instrOut), 32'h0);
    cyc(0, 16'h0, 16'h0, 1, 0);
    chk("fl_stay_empty", 32'(outValid), 32'd0);
    chk("fl_no_3333", 32'(instrOut != 16'h3333), 32'd1);

    // Asynchronous reset between edges while full
    cyc(1, 16'h7777, 16'h0072, 0, 0);
    cyc(1, 16'h8888, 16'h0082, 0, 0);
    chk("ar_pre_count", 32'(count), 32'd2);
    inValid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("ar_count", 32'(count), 32'd0);
    chk("ar_outValid", 32'(outValid), 32'd0);
    chk("ar_inReady", 32'(inReady), 32'd1);
    chk("ar_instr", 32'(instrOut), 32'h0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    cyc(1, 16'h4444, 16'h0046, 0, 0);
    chk("ar_post_valid", 32'(outValid), 32'd1);
    chk("ar_post_instr", 32'(instrOut), 32'h4444);
    chk("ar_post_count", 32'(count), 32'd1);
    cyc(0, 16'h0, 16'h0, 1, 0);

    // Random traffic; the monitor does the checking
    for (int i = 0; i < 200; i++) begin
      cyc(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
    end
    for (int i = 0; i < 4; i++) cyc(0, 16'h0, 16'h0, 1, 0);
    chk("final_empty", 32'(count), 32'd0);

    @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 Parameter WIDTH, 16, instruction and PC word width in bits.
REQ-002 Parameter DEPTH, 2, number of buffered fetch entries; only the value 2 is supported.
REQ-003 Port clock  input  1  single clock; all state updates on the rising edge.
REQ-004 Port reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port inValid  input  1  fetch stage presents a valid instruction this cycle.
REQ-006 Port instrIn  input  WIDTH  fetched instruction word.
REQ-007 Port pc4In  input  WIDTH  incremented PC (PC+4) belonging to instrIn.
REQ-008 Port inReady  output  1  queue can accept an entry; fetch holds its PC (deasserts PCWrite) while this is 0.
REQ-009 Port flush  input  1  taken branch or PCSrc redirect; discards all queued instructions.
REQ-010 Port outValid  output  1  head entry is valid for decode.
REQ-011 Port instrOut  output  WIDTH  head instruction.
REQ-012 Port pc4Out  output  WIDTH  head PC+4.
REQ-013 Port outReady  input  1  decode consumes the head this cycle (not stalled).
REQ-014 Port count  output  2  number of occupied entries, 0..2.

Function
REQ-015 Push: occurs when inValid=1, inReady=1 and flush=0; the entry is written at the tail.
REQ-016 Pop: occurs when outValid=1, outReady=1 and flush=0; the head advances.
REQ-017 inReady SHALL be 1 exactly when count<DEPTH, derived from registered state only, with no combinational path from outReady.
REQ-018 outValid SHALL be 1 exactly when count>0, with no bypass: an entry pushed at edge N is first visible after edge N (1-cycle latency).
REQ-019 When outValid=0, instrOut SHALL be the NOP encoding 16'h0000 and pc4Out SHALL be 16'h0000.
REQ-020 Simultaneous push and pop with count=1 SHALL leave count=1, with the new entry becoming the head.
REQ-021 When full (count=2), a push SHALL NOT be accepted even if a pop occurs in the same cycle; count then becomes 1.
REQ-022 Entries SHALL leave in FIFO order; head and tail pointers are 1 bit wide and wrap 1->0.
REQ-023 flush=1 SHALL take priority over push and pop: at the next edge count=0 and both pointers=0, and any same-cycle inValid entry is dropped.
REQ-024 Storage contents are not cleared by flush; only valid state is cleared, and outputs are masked per REQ-019.
REQ-025 Instruction bits SHALL pass through unmodified; no decoding occurs in this block.

Reset
REQ-026 Asserting reset_n=0 SHALL immediately, independent of clock, force count=0, both pointers=0, outValid=0, inReady=1, instrOut=16'h0000 and pc4Out=16'h0000.
REQ-027 Reset asserted mid-operation SHALL discard all queued entries, with no partial pop or push.
REQ-028 The first push SHALL be possible at the first rising edge after reset_n deasserts.

Structure
REQ-029 NOP encoding (16'h0000), WIDTH and DEPTH defaults SHALL reside in the shared processor constants include, also used by decode.
REQ-030 The block SHALL be a single module holding a 2-entry register array, two 1-bit pointers and a 2-bit count; no sub-module is instantiated.

Verification
REQ-031 Reset, then push 16'h1234 with pc4 16'h0002 and outReady=0 -> the following cycle outValid=1, instrOut=16'h1234, pc4Out=16'h0002, count=1.
REQ-032 Push 16'hAAAA and 16'hBBBB with outReady=0 -> count=2, inReady=0; a third push of 16'hCCCC is ignored; then pop twice -> outputs are AAAA then BBBB, then outValid=0 and instrOut=16'h0000.
REQ-033 count=1 (head 16'h1111) with push 16'h2222 and pop in the same cycle -> next cycle count=1, instrOut=16'h2222.
REQ-034 count=2 with flush=1 and inValid=1 (16'h3333) in the same cycle -> next cycle count=0, outValid=0, inReady=1, and 16'h3333 never appears at the output.
REQ-035 count=2, reset_n pulled low between clock edges -> outValid=0 and count=0 before the next edge; after release, push 16'h4444 appears one cycle later.
REQ-036 Randomised push/pop sequence of 200 cycles against a scoreboard FIFO -> output order matches, count never exceeds 2, inReady always equals (count<2).
